// File: rtl/ex_pkg.sv
// Shared widths, operation encodings and divider state encodings for the EX stage.
package ex_pkg;

    localparam int ALUOPBUS   = 8;
    localparam int ALUSELBUS  = 3;
    localparam int REGBUS     = 32;
    localparam int REGADDRBUS = 5;

    localparam logic                  RSTENABLE    = 1'b1;
    localparam logic [REGBUS-1:0]     ZEROWORD     = '0;
    localparam logic [REGADDRBUS-1:0] NOPREGADDR   = '0;
    localparam logic                  WRITEDISABLE = 1'b0;
    localparam logic                  WRITEENABLE  = 1'b1;

    localparam logic [ALUOPBUS-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOPBUS-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALUOPBUS-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALUOPBUS-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALUOPBUS-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALUOPBUS-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALUOPBUS-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALUOPBUS-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALUOPBUS-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [ALUOPBUS-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALUOPBUS-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [ALUOPBUS-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [ALUOPBUS-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [ALUOPBUS-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [ALUOPBUS-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [ALUOPBUS-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [ALUOPBUS-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOPBUS-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALUOPBUS-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALUOPBUS-1:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [ALUSELBUS-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSELBUS-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSELBUS-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [ALUSELBUS-1:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [ALUSELBUS-1:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BUSY   = 2'b01,
        DIV_BYZERO = 2'b10,
        DIV_DONE   = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; master is the upstream/downstream pipeline side.
interface ex_if;
    import ex_pkg::*;

    logic [ALUOPBUS-1:0]   aluop_i;
    logic [ALUSELBUS-1:0]  alusel_i;
    logic [REGBUS-1:0]     reg1_i;
    logic [REGBUS-1:0]     reg2_i;
    logic [REGADDRBUS-1:0] wd_i;
    logic                  wreg_i;
    logic [REGBUS-1:0]     hi_i;
    logic [REGBUS-1:0]     lo_i;

    logic [REGADDRBUS-1:0] wd_o;
    logic                  wreg_o;
    logic [REGBUS-1:0]     wdata_o;
    logic                  whilo_o;
    logic [REGBUS-1:0]     hi_o;
    logic [REGBUS-1:0]     lo_o;
    logic                  stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_div.sv
// Iterative 32-step restoring divider; signed mode divides magnitudes and fixes signs at the end.
module div
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [REGBUS-1:0]     opdata1_i,
    input  logic [REGBUS-1:0]     opdata2_i,
    input  logic                  start_i,
    output logic [2*REGBUS-1:0]   result_o,
    output logic                  ready_o
);

    div_state_e state, state_nxt;

    logic [4:0]          cnt;
    logic [REGBUS-1:0]   rem, quo, dvs;
    logic                neg_q, neg_r;
    logic [2*REGBUS-1:0] result;
    logic [REGBUS:0]     partial, diff;
    logic [REGBUS-1:0]   rem_nxt, quo_nxt;

    function automatic logic [REGBUS-1:0] mag(input logic signed [REGBUS-1:0] v,
                                              input logic is_signed);
        return (is_signed && v[REGBUS-1]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [REGBUS-1:0] apply_sign(input logic [REGBUS-1:0] v,
                                                     input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // One restoring step: the remainder stays below the divisor, so 33 bits hold the trial.
    always_comb begin
        partial = {rem, quo[REGBUS-1]};
        diff    = partial - {1'b0, dvs};
        rem_nxt = diff[REGBUS] ? partial[REGBUS-1:0] : diff[REGBUS-1:0];
        quo_nxt = {quo[REGBUS-2:0], ~diff[REGBUS]};
    end

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start_i)
                    state_nxt = (opdata2_i == ZEROWORD) ? DIV_BYZERO : DIV_BUSY;
            end
            DIV_BUSY: begin
                if (!start_i)
                    state_nxt = DIV_IDLE;
                else if (cnt == 5'd31)
                    state_nxt = DIV_DONE;
            end
            DIV_BYZERO: begin
                state_nxt = start_i ? DIV_DONE : DIV_IDLE;
            end
            DIV_DONE: begin
                ready_o   = 1'b1;
                state_nxt = DIV_IDLE;
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == DIV_BUSY)
                cnt <= cnt + 5'd1;
            else
                cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == DIV_IDLE && start_i) begin
            rem   <= '0;
            quo   <= mag(opdata1_i, signed_div_i);
            dvs   <= mag(opdata2_i, signed_div_i);
            neg_q <= signed_div_i & (opdata1_i[REGBUS-1] ^ opdata2_i[REGBUS-1]);
            neg_r <= signed_div_i & opdata1_i[REGBUS-1];
        end else if (state == DIV_BUSY) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

    // Result only changes on completion or divide-by-zero, so an annulled run leaves no trace.
    always_ff @(posedge clk) begin
        if (rst)
            result <= '0;
        else if (state == DIV_BYZERO)
            result <= '0;
        else if (state == DIV_BUSY && start_i && cnt == 5'd31)
            result <= {apply_sign(rem_nxt, neg_r), apply_sign(quo_nxt, neg_q)};
    end

    assign result_o = result;

endmodule

// File: rtl/ex.sv
// MIPS execute stage: single-cycle logic/shift/move/arith/multiply, stalling iterative divide.
module ex
    import ex_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    logic signed [REGBUS-1:0]   op1_s, op2_s;
    logic [4:0]                 shamt;
    logic signed [2*REGBUS-1:0] prod_s;
    logic [2*REGBUS-1:0]        prod_u;
    logic [REGBUS-1:0]          logic_res, shift_res, move_res, arith_res;
    logic                       is_div, div_signed, div_start, div_ready;
    logic [2*REGBUS-1:0]        div_result;

    logic [REGADDRBUS-1:0] wd;
    logic                  wreg;
    logic [REGBUS-1:0]     wdata, hi, lo;
    logic                  whilo, stallreq;

    assign op1_s  = bus.reg1_i;
    assign op2_s  = bus.reg2_i;
    assign shamt  = bus.reg1_i[4:0];
    assign prod_s = 64'(op1_s) * 64'(op2_s);
    assign prod_u = {32'd0, bus.reg1_i} * {32'd0, bus.reg2_i};

    assign is_div     = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
    assign div_signed = (bus.aluop_i == EXE_DIV_OP);
    assign div_start  = is_div && !div_ready;

    div u_div (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (div_signed),
        .opdata1_i    (bus.reg1_i),
        .opdata2_i    (bus.reg2_i),
        .start_i      (div_start),
        .result_o     (div_result),
        .ready_o      (div_ready)
    );

    always_comb begin
        logic_res = ZEROWORD;
        shift_res = ZEROWORD;
        move_res  = ZEROWORD;
        arith_res = ZEROWORD;
        case (bus.aluop_i)
            EXE_OR_OP:   logic_res = bus.reg1_i | bus.reg2_i;
            EXE_AND_OP:  logic_res = bus.reg1_i & bus.reg2_i;
            EXE_XOR_OP:  logic_res = bus.reg1_i ^ bus.reg2_i;
            EXE_NOR_OP:  logic_res = ~(bus.reg1_i | bus.reg2_i);
            EXE_SLL_OP:  shift_res = bus.reg2_i << shamt;
            EXE_SRL_OP:  shift_res = bus.reg2_i >> shamt;
            EXE_SRA_OP:  shift_res = op2_s >>> shamt;
            EXE_MFHI_OP: move_res  = bus.hi_i;
            EXE_MFLO_OP: move_res  = bus.lo_i;
            EXE_ADDU_OP: arith_res = bus.reg1_i + bus.reg2_i;
            EXE_SUBU_OP: arith_res = bus.reg1_i - bus.reg2_i;
            EXE_SLT_OP:  arith_res = {31'd0, op1_s < op2_s};
            EXE_SLTU_OP: arith_res = {31'd0, bus.reg1_i < bus.reg2_i};
            default: ;
        endcase
    end

    // Reset forces every output to its idle value regardless of the instruction in EX.
    always_comb begin
        wd       = NOPREGADDR;
        wreg     = WRITEDISABLE;
        wdata    = ZEROWORD;
        whilo    = 1'b0;
        hi       = ZEROWORD;
        lo       = ZEROWORD;
        stallreq = 1'b0;
        if (rst != RSTENABLE) begin
            wd   = bus.wd_i;
            wreg = bus.wreg_i;
            case (bus.alusel_i)
                EXE_RES_LOGIC: wdata = logic_res;
                EXE_RES_SHIFT: wdata = shift_res;
                EXE_RES_MOVE:  wdata = move_res;
                EXE_RES_ARITH: wdata = arith_res;
                default:       wdata = ZEROWORD;
            endcase
            case (bus.aluop_i)
                EXE_MTHI_OP: begin
                    whilo = 1'b1;
                    hi    = bus.reg1_i;
                    lo    = bus.lo_i;
                end
                EXE_MTLO_OP: begin
                    whilo = 1'b1;
                    hi    = bus.hi_i;
                    lo    = bus.reg1_i;
                end
                EXE_MULT_OP: begin
                    whilo = 1'b1;
                    {hi, lo} = prod_s;
                end
                EXE_MULTU_OP: begin
                    whilo = 1'b1;
                    {hi, lo} = prod_u;
                end
                EXE_DIV_OP, EXE_DIVU_OP: begin
                    stallreq = !div_ready;
                    if (div_ready) begin
                        whilo = 1'b1;
                        {hi, lo} = div_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wd_o       = wd;
    assign bus.wreg_o     = wreg;
    assign bus.wdata_o    = wdata;
    assign bus.whilo_o    = whilo;
    assign bus.hi_o       = hi;
    assign bus.lo_o       = lo;
    assign bus.stallreq_o = stallreq;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the EX stage: vector table for single-cycle ops, hand sequences for divides.
module tb_ex;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ex_if bus ();

    ex dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1, r2, hi, lo;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp_wdata;
        logic        exp_whilo;
        logic [31:0] exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic addv(input string n, input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input logic [4:0] wd, input logic wreg,
                        input logic [31:0] ew, input logic eh,
                        input logic [31:0] ehi, input logic [31:0] elo);
        vec_t v;
        v.name = n; v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2; v.hi = hi; v.lo = lo;
        v.wd = wd; v.wreg = wreg; v.exp_wdata = ew; v.exp_whilo = eh;
        v.exp_hi = ehi; v.exp_lo = elo;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic [4:0] wd, input logic wreg);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.hi_i     = hi;
        bus.lo_i     = lo;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
    endtask

    task automatic check_all_zero(input string n);
        check({n, "_wd"},    64'(bus.wd_o), 64'd0);
        check({n, "_wreg"},  64'(bus.wreg_o), 64'd0);
        check({n, "_wdata"}, 64'(bus.wdata_o), 64'd0);
        check({n, "_whilo"}, 64'(bus.whilo_o), 64'd0);
        check({n, "_hilo"},  {bus.hi_o, bus.lo_o}, 64'd0);
        check({n, "_stall"}, 64'(bus.stallreq_o), 64'd0);
    endtask

    // Start a divide at the next negedge (its cycle 0) and follow it until stall drops.
    task automatic run_div(input string n, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        int   stalls = 0;
        int   early  = 0;
        bit   done   = 0;
        logic wh = 1'b0;
        logic [31:0] h = '0, l = '0;
        @(negedge clk);
        drive(op, EXE_RES_NOP, a, b, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus.stallreq_o) begin
                stalls++;
                if (bus.whilo_o) early++;
                @(negedge clk);
            end else begin
                done = 1;
                wh = bus.whilo_o;
                h  = bus.hi_o;
                l  = bus.lo_o;
            end
        end
        check({n, "_finished"}, 64'(done), 64'd1);
        check({n, "_stall_cycles"}, 64'(stalls), 64'(ecyc));
        check({n, "_early_whilo"}, 64'(early), 64'd0);
        check({n, "_whilo"}, 64'(wh), 64'd1);
        check({n, "_hi"}, 64'(h), 64'(ehi));
        check({n, "_lo"}, 64'(l), 64'(elo));
    endtask

    initial begin
        int hits;
        logic [7:0] rst_ops[3];

        addv("or",    EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF0000, 0, 0, 5'd5, 1'b1, 32'h00FFF0F0, 1'b0, 0, 0);
        addv("and",   EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 0, 0, 5'd6, 1'b1, 32'h0F000F00, 1'b0, 0, 0);
        addv("xor",   EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 0, 0, 5'd7, 1'b1, 32'hF0F00F0F, 1'b0, 0, 0);
        addv("nor",   EXE_NOR_OP,  EXE_RES_LOGIC, 32'h00000000, 32'h0000FFFF, 0, 0, 5'd8, 1'b1, 32'hFFFF0000, 1'b0, 0, 0);
        addv("sll",   EXE_SLL_OP,  EXE_RES_SHIFT, 32'd4, 32'h0000000F, 0, 0, 5'd9, 1'b1, 32'h000000F0, 1'b0, 0, 0);
        addv("srl",   EXE_SRL_OP,  EXE_RES_SHIFT, 32'd4, 32'h80000000, 0, 0, 5'd10, 1'b1, 32'h08000000, 1'b0, 0, 0);
        addv("sra",   EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4, 32'h80000000, 0, 0, 5'd11, 1'b1, 32'hF8000000, 1'b0, 0, 0);
        addv("sra_amt_mask", EXE_SRA_OP, EXE_RES_SHIFT, 32'h24, 32'h7FFFFFF0, 0, 0, 5'd12, 1'b1, 32'h07FFFFFF, 1'b0, 0, 0);
        addv("addu_wrap", EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd2, 0, 0, 5'd13, 1'b1, 32'h00000001, 1'b0, 0, 0);
        addv("subu_wrap", EXE_SUBU_OP, EXE_RES_ARITH, 32'd1, 32'd2, 0, 0, 5'd14, 1'b1, 32'hFFFFFFFF, 1'b0, 0, 0);
        addv("slt",   EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1, 0, 0, 5'd15, 1'b1, 32'd1, 1'b0, 0, 0);
        addv("sltu",  EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1, 0, 0, 5'd16, 1'b1, 32'd0, 1'b0, 0, 0);
        addv("mfhi",  EXE_MFHI_OP, EXE_RES_MOVE, 0, 0, 32'h12345678, 32'h9ABCDEF0, 5'd17, 1'b1, 32'h12345678, 1'b0, 0, 0);
        addv("mflo",  EXE_MFLO_OP, EXE_RES_MOVE, 0, 0, 32'h12345678, 32'h9ABCDEF0, 5'd18, 1'b1, 32'h9ABCDEF0, 1'b0, 0, 0);
        addv("mthi",  EXE_MTHI_OP, EXE_RES_NOP, 32'hAAAA5555, 0, 32'h1, 32'h2, 5'd0, 1'b0, 32'd0, 1'b1, 32'hAAAA5555, 32'h2);
        addv("mtlo",  EXE_MTLO_OP, EXE_RES_NOP, 32'h5555AAAA, 0, 32'h1, 32'h2, 5'd0, 1'b0, 32'd0, 1'b1, 32'h1, 32'h5555AAAA);
        addv("mult",  EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 0, 0, 5'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        addv("multu", EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 0, 0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h00000002, 32'hFFFFFFFA);
        addv("nop",   EXE_NOP_OP,  EXE_RES_NOP, 32'h12345678, 32'h9ABCDEF0, 0, 0, 5'd3, 1'b1, 32'd0, 1'b0, 0, 0);

        // Reset holds every output at zero, whatever sits in EX.
        rst_ops[0] = EXE_OR_OP;
        rst_ops[1] = EXE_MULT_OP;
        rst_ops[2] = EXE_DIV_OP;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(rst_ops[i], EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF0000, 32'h11, 32'h22, 5'd5, 1'b1);
            #1;
            check_all_zero("reset");
        end
        @(negedge clk);
        rst = 1'b0;
        drive(EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 0, 5'd0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].hi, vecs[i].lo,
                  vecs[i].wd, vecs[i].wreg);
            #1;
            check({vecs[i].name, "_wdata"}, 64'(bus.wdata_o), 64'(vecs[i].exp_wdata));
            check({vecs[i].name, "_wd"},    64'(bus.wd_o), 64'(vecs[i].wd));
            check({vecs[i].name, "_wreg"},  64'(bus.wreg_o), 64'(vecs[i].wreg));
            check({vecs[i].name, "_whilo"}, 64'(bus.whilo_o), 64'(vecs[i].exp_whilo));
            check({vecs[i].name, "_stall"}, 64'(bus.stallreq_o), 64'd0);
            if (vecs[i].exp_whilo)
                check({vecs[i].name, "_hilo"}, {bus.hi_o, bus.lo_o},
                      {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        run_div("div_m7_2",  EXE_DIV_OP,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_div("divu_7_2",  EXE_DIVU_OP, 32'd7, 32'd2, 32'd1, 32'd3, 33);
        run_div("div_7_m2",  EXE_DIV_OP,  32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
        run_div("divu_by0",  EXE_DIVU_OP, 32'd55, 32'd0, 32'd0, 32'd0, 2);

        // Reset in cycle 10 of a divide: nothing from that divide may ever surface.
        @(negedge clk);
        drive(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFFFFF9, 32'd2, 0, 0, 5'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        drive(EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 0, 5'd0, 1'b0);
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.whilo_o || bus.stallreq_o) hits++;
            @(negedge clk);
        end
        check("midrst_no_result", 64'(hits), 64'd0);
        run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
